mouse_receiver: RTL and testbench

Host-side PS/2 receiver: the device-to-host counterpart of the mouse transmitter. Monitors the open-drain mouse clock/data lines, deserialises 11-bit device frames (start, 8 data LSB-first, odd parity, stop), and presents each byte with error flags and a one-cycle ready strobe to the mouse master state machine. Never drives the bus; shares the line inputs with the transmitter.

---
 rtl/mouse_receiver.sv | 176 +++++++++++++++++
 tb/tb_mouse_receiver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mouse_receiver.sv
// -----------------------------------------------------------------------------
// mouse_receiver
//   Host-side PS/2 receiver. Watches the open-drain mouse clock/data lines,
//   deserialises 11-bit device frames (start, 8 data bits LSB first, odd
//   parity, stop) and hands each byte to the mouse master with error flags and
//   a one-cycle ready strobe. Purely a listener: it never drives the bus and
//   shares the line inputs with the transmitter.
//
// Parameters
//   TIMEOUT          max CLK cycles allowed between bus clock falls in a frame
//
// Ports
//   CLK              system clock
//   RESET            synchronous, active-high reset
//   CLK_MOUSE_IN     raw PS/2 clock line (asynchronous)
//   DATA_MOUSE_IN    raw PS/2 data line (asynchronous)
//   READ_ENABLE      1 = accept new frames; only looked at while idle
//   BYTE_READ        last received data byte
//   BYTE_ERROR_CODE  {stop-bit error, parity error} for BYTE_READ
//   BYTE_READY       one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
// -----------------------------------------------------------------------------
module mouse_receiver #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. They reset to 1 (idle bus level) so that coming
  // out of reset never looks like a clock fall.
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q;
  logic data_s1_q, data_s2_q;
  logic fall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= CLK_MOUSE_IN;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= DATA_MOUSE_IN;
      data_s2_q <= data_s1_q;
    end
  end

  // Fall is flagged one stage early (s2 old high, s1 new low); data is taken
  // from the matching stage, data_s1, so clock and data stay aligned.
  assign fall = clk_s2_q & ~clk_s1_q;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t      state_q,  state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q,  shift_d;
  logic        par_q,    par_d;
  logic [15:0] tmo_q,    tmo_d;
  logic        perr_q,   perr_d;
  logic        serr_q,   serr_d;
  logic [7:0]  byte_q,   byte_d;
  logic [1:0]  code_q,   code_d;
  logic        rdy_q,    rdy_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      tmo_q    <= 16'd0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      byte_q   <= 8'h00;
      code_q   <= 2'b00;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      byte_q   <= byte_d;
      code_q   <= code_d;
      rdy_q    <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = 16'd0;
    perr_d   = perr_q;
    serr_d   = serr_q;
    byte_d   = byte_q;
    code_d   = code_q;
    rdy_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Only a low start bit opens a frame; a fall with data high is noise.
        if (fall && READ_ENABLE && !data_s1_q) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end

      S_DATA, S_PARITY, S_STOP: begin
        // A fall takes priority over an expiring timeout: the bit is kept.
        if (fall) begin
          tmo_d = 16'd0;
          case (state_q)
            S_DATA: begin
              shift_d[bitcnt_q] = data_s1_q;
              if (bitcnt_q == 3'd7) state_d = S_PARITY;
              else                  bitcnt_d = bitcnt_q + 3'd1;
            end
            S_PARITY: begin
              par_d   = data_s1_q;
              state_d = S_STOP;
            end
            default: begin
              // Odd parity: the parity bit must equal the XNOR of the data.
              perr_d  = (par_q != ~^shift_q);
              serr_d  = ~data_s1_q;
              state_d = S_DONE;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Stalled bus: drop the partial frame silently.
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_DONE: begin
        byte_d  = shift_q;
        code_d  = {serr_q, perr_q};
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign BYTE_READ       = byte_q;
  assign BYTE_ERROR_CODE = code_q;
  assign BYTE_READY      = rdy_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// -----------------------------------------------------------------------------
// tb_mouse_receiver
//   Directed frames with hand-computed bytes/error codes. The driver pushes the
//   expected delivery (byte, code, strobe cycle) when it drives the stop-bit
//   fall; a monitor pops and checks on every BYTE_READY. A shortened TIMEOUT
//   and a fast bus clock keep the run short.
// -----------------------------------------------------------------------------
module tb_mouse_receiver;

  localparam int TMO  = 200;
  localparam int HALF = 40;   // bus half-period in CLK cycles

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLK_MOUSE_IN = 1'b1;
  logic       DATA_MOUSE_IN = 1'b1;
  logic       READ_ENABLE = 1'b1;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  mouse_receiver #(.TIMEOUT(TMO)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .CLK_MOUSE_IN    (CLK_MOUSE_IN),
    .DATA_MOUSE_IN   (DATA_MOUSE_IN),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic [1:0] c;
    int         t;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation and be one cycle.
  logic prev_rdy = 1'b0;
  always @(negedge CLK) begin
    if (BYTE_READY === 1'b1) begin
      exp_t e;
      if (prev_rdy) chk("strobe_width", 32'd2, 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_strobe", {24'd0, BYTE_READ}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("byte",    {24'd0, BYTE_READ},       {24'd0, e.b});
        chk("code",    {30'd0, BYTE_ERROR_CODE}, {30'd0, e.c});
        chk("latency", cyc,                      e.t);
      end
    end
    prev_rdy = (BYTE_READY === 1'b1);
  end

  // Drive the first nbits of a frame. If expect_it, the delivery is queued at
  // the stop-bit fall: sync (1) + detect (1) + DONE (1) = strobe 3 cycles later.
  task automatic send(input logic [7:0] d, input logic par, input logic stp,
                      input int nbits, input bit expect_it, input logic [1:0] code);
    logic [10:0] fr;
    exp_t e;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      DATA_MOUSE_IN = fr[i];
      repeat (HALF) @(negedge CLK);
      CLK_MOUSE_IN = 1'b0;
      if (i == 10 && expect_it) begin
        e.b = d; e.c = code; e.t = cyc + 3;
        q.push_back(e);
      end
      repeat (HALF) @(negedge CLK);
      CLK_MOUSE_IN = 1'b1;
    end
    DATA_MOUSE_IN = 1'b1;
    repeat (HALF) @(negedge CLK);
  endtask

  initial begin
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_byte",  {24'd0, BYTE_READ},       32'h00);
    chk("rst_code",  {30'd0, BYTE_ERROR_CODE}, 32'h0);
    chk("rst_ready", {31'd0, BYTE_READY},      32'h0);

    // Good frame, parity error, stop-bit error.
    send(8'hFA, 1'b1, 1'b1, 11, 1'b1, 2'b00);
    send(8'h00, 1'b0, 1'b1, 11, 1'b1, 2'b01);
    send(8'hAA, 1'b1, 1'b0, 11, 1'b1, 2'b10);

    // Truncated frame then silence past TIMEOUT: dropped, outputs held.
    send(8'h08, 1'b0, 1'b1, 5, 1'b0, 2'b00);
    repeat (TMO + 100) @(negedge CLK);
    chk("tmo_hold_byte", {24'd0, BYTE_READ},       32'hAA);
    chk("tmo_hold_code", {30'd0, BYTE_ERROR_CODE}, 32'h2);
    send(8'h08, 1'b0, 1'b1, 11, 1'b1, 2'b00);

    // Receiver disabled: frame ignored.
    READ_ENABLE = 1'b0;
    send(8'hF4, 1'b0, 1'b1, 11, 1'b0, 2'b00);
    chk("dis_hold_byte", {24'd0, BYTE_READ},       32'h08);
    chk("dis_hold_code", {30'd0, BYTE_ERROR_CODE}, 32'h0);
    READ_ENABLE = 1'b1;
    send(8'hF4, 1'b0, 1'b1, 11, 1'b1, 2'b00);

    // Reset in the middle of a frame.
    send(8'h55, 1'b1, 1'b1, 4, 1'b0, 2'b00);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("mid_rst_byte",  {24'd0, BYTE_READ},       32'h00);
    chk("mid_rst_code",  {30'd0, BYTE_ERROR_CODE}, 32'h0);
    chk("mid_rst_ready", {31'd0, BYTE_READY},      32'h0);
    repeat (TMO) @(negedge CLK);
    send(8'h55, 1'b1, 1'b1, 11, 1'b1, 2'b00);

    repeat (20) @(negedge CLK);
    chk("pending_expected", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
